// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, sticky
// error flags, and either a registered read port or first-word-fall-through.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc_s;
  logic              wr_acc_s;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == {CW{1'b0}});
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept/reject decisions and next-state for pointers, occupancy and error flags.
  always_comb begin
    rd_acc_s = rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    wr_acc_s = wr_en & (~full | rd_acc_s);

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d     = count_q + CW'(wr_acc_s) - CW'(rd_acc_s);
    overflow_d  = (overflow_q  & ~clr_err) | (wr_en & ~wr_acc_s);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & ~rd_acc_s);
  end

  // Control state registers; reset empties the FIFO and clears errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Registered read port: data captured on an accepted read, valid pulses once.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= {DATA_W{1'b0}};
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc_s;
        if (rd_acc_s) begin
          rd_data_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench driving a standard-read and an FWFT instance
// with identical stimulus against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_err;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae;
  logic [4:0]    s_count, f_count;
  logic          s_ov, f_ov, s_un, f_un;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ov), .underflow(f_un)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mq[$];
  logic          m_ov, m_un;
  logic [DW-1:0] m_last;
  int            cyc;
  int            n_checks;
  int            n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Post-edge comparison of both instances against the model.
  task automatic chk_state();
    int sz;
    sz = mq.size();
    chk("s_count", 32'(s_count), 32'(sz));
    chk("s_full", 32'(s_full), 32'(sz == DP));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("s_almost_full", 32'(s_af), 32'(sz >= AF));
    chk("s_almost_empty", 32'(s_ae), 32'(sz <= AE));
    chk("s_overflow", 32'(s_ov), 32'(m_ov));
    chk("s_underflow", 32'(s_un), 32'(m_un));
    chk("s_rd_data_hold", 32'(s_rd_data), 32'(m_last));
    chk("f_count", 32'(f_count), 32'(sz));
    chk("f_empty", 32'(f_empty), 32'(sz == 0));
    chk("f_overflow", 32'(f_ov), 32'(m_ov));
    chk("f_underflow", 32'(f_un), 32'(m_un));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(sz > 0));
    if (sz > 0) chk("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic c, input logic rst);
    bit ra, wa;
    logic [DW-1:0] x;
    wr_en = w; rd_en = r; wr_data = d; clr_err = c; reset = rst;
    if (rst) begin
      mq.delete();
      m_ov = 1'b0; m_un = 1'b0; m_last = '0;
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < DP) || ra);
      m_ov = (m_ov && !c) || (w && !wa);
      m_un = (m_un && !c) || (r && !ra);
      if (ra) begin
        x = mq.pop_front();
        exp_q.push_back('{d: x, e: cyc + 1});
        m_last = x;
      end
      if (wa) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    chk_state();
  endtask

  // Monitor: each standard-mode rd_valid must match the oldest issued read, on time.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (s_rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_spurious", 32'd1, 32'd0);
        end else begin
          it = exp_q.pop_front();
          chk("rd_data", 32'(s_rd_data), 32'(it.d));
          chk("rd_latency", 32'(cyc), 32'(it.e));
        end
      end else if (exp_q.size() > 0 && exp_q[0].e <= cyc) begin
        it = exp_q.pop_front();
        chk("rd_valid_missing", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    int written;
    bit w, r;
    n_checks = 0; n_fail = 0;
    m_ov = 1'b0; m_un = 1'b0; m_last = '0;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; clr_err = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill with 0x01..0x10, then one rejected write.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous write+read while full, then drain to see the wrapped word.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    // Simultaneous write+read while empty.
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Single word into empty FIFO, then one pop.
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Wrap-around stream of 40 words with occupancy kept within 3..12.
    written = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
      written++;
    end
    while (written < 40) begin
      w = (mq.size() < 12) && ($urandom_range(0, 1) == 1);
      r = (mq.size() > 3) && ($urandom_range(0, 1) == 1);
      step(w, r, 8'($urandom), 1'b0, 1'b0);
      if (w) written++;
    end
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Reset with count=7 and overflow set, in-flight write+read discarded.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(s_count), 32'd7);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);

    // clr_err coincident with a rejected write keeps overflow set.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    chk("ov_set_wins", 32'(s_ov), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Unconstrained random traffic with occasional clr_err and reset.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
